rock_speed_ramp: RTL and testbench
==================================

// Module: rock_speed_ramp
// PURPOSE
//  Soft-start / soft-stop scheduler for the rocking motor clock divider.
//  Drives the divider's 8-bit delay input (larger = slower). On start it
//  walks delay_val from SLOW_VAL down to a target in STEP increments, one
//  step every DWELL divider ticks. It holds there and tracks target changes.
//  On stop it ramps back to SLOW_VAL, then drops motor_en.
//  Sits between the user speed selector and the divider; the divider's
//  SlowClk output feeds back as tick.
// PARAMETERS
//  STEP      4    delay units moved per ramp step (1..255)
//  DWELL     8    divider ticks between ramp steps (1..255)
//  SLOW_VAL  255  parked/idle delay value, slowest rocking rate
// PORTS
//  CLK        in   1  system clock, all logic on rising edge
//  Reset      in   1  synchronous, active-low (Reset==0 resets on CLK edge)
//  start      in   1  1-cycle request: begin ramp to target
//  stop       in   1  1-cycle request: ramp down and park
//  target     in   8  requested delay value; values >SLOW_VAL clamp to SLOW_VAL
//  tick       in   1  1-cycle pulse from divider SlowClk
//  delay_val  out  8  delay value to divider input
//  motor_en   out  1  motor drive enable
//  at_speed   out  1  1 while delay_val==latched target in HOLD
//  busy       out  1  1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, delay_val=SLOW_VAL, tgt_q=SLOW_VAL, dwell_cnt=0,
//   motor_en=0, at_speed=0, busy=0. Reset overrides every other input.
//  States: IDLE, RAMP, HOLD, STOPPING. All outputs are registered.
//  IDLE: start=1 -> latch tgt_q=clamp(target), dwell_cnt=0, motor_en=1,
//   busy=1 on the next edge. Go to RAMP, or to HOLD if tgt_q==delay_val.
//  RAMP: counts tick pulses only. On a tick with dwell_cnt==DWELL-1:
//   dwell_cnt=0 and delay_val moves one STEP toward tgt_q. Otherwise on
//   tick: dwell_cnt++. The new delay_val is visible 1 CLK after the tick.
//   When delay_val==tgt_q -> HOLD (at_speed=1 on the following edge).
//  Step arithmetic: 9-bit, saturating at tgt_q, never overshoots.
//   Down: if delay_val-STEP < tgt_q (incl. borrow) -> delay_val=tgt_q.
//   Up: if delay_val+STEP > tgt_q (incl. carry) -> delay_val=tgt_q.
//  HOLD: tgt_q reloads from clamp(target) every cycle. If it differs from
//   delay_val: at_speed=0, dwell_cnt=0, -> RAMP. Direction comes from the
//   compare.
//  stop=1 in RAMP/HOLD -> STOPPING: tgt_q=SLOW_VAL, dwell_cnt=0, at_speed=0.
//   Ramps up with the same DWELL/STEP rule. At delay_val==SLOW_VAL:
//   motor_en=0, busy=0, -> IDLE.
//  Simultaneous start & stop: stop wins. In IDLE both together = no-op.
//  start in RAMP/HOLD: relatch tgt_q, dwell_cnt=0, stay or go to RAMP.
//   start in STOPPING is ignored; the stop always completes.
//  stop in IDLE or STOPPING: ignored.
//  tick while not in RAMP/STOPPING: ignored, dwell_cnt holds 0.
//  Reset mid-ramp: immediate park (delay_val=SLOW_VAL, motor_en=0), no ramp.
// TESTING (bench: STEP=4, DWELL=2, SLOW_VAL=255, tick every 5 CLK)
//  Soft start: start, target=243.
//   -> motor_en=1 next cycle. delay_val 255->251->247->243, one step
//      every 2nd tick. Then HOLD, at_speed=1.
//  Saturation: start, target=253.
//   -> delay_val 255->253 in one step (no overshoot). at_speed=1.
//  Retarget in HOLD at 243, target->250.
//   -> at_speed=0. delay_val 243->247->250. at_speed=1.
//  Stop from HOLD at 248.
//   -> delay_val 248->252->255. motor_en=0, busy=0 one cycle after 255.
//  Priority: start&stop together in RAMP -> STOPPING.
//   start during STOPPING -> ignored, still ends IDLE.
//  Reset=0 mid-RAMP at 247.
//   -> next edge: delay_val=255, motor_en=0, busy=0, state IDLE.
//  Clamp: SLOW_VAL=200, target=230 -> tgt_q=200, direct to HOLD, at_speed=1.

Source files
------------

// File: rtl/rock_speed_ramp.sv
// ============================================================================
// rock_speed_ramp : soft-start / soft-stop delay scheduler for the rocking
// motor clock divider.                                       rev 1.0
// ============================================================================
`default_nettype none

module rock_speed_ramp #(
  parameter int STEP     = 4,
  parameter int DWELL    = 8,
  parameter int SLOW_VAL = 255
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] target,
  input  logic       tick,
  output logic [7:0] delay_val,
  output logic       motor_en,
  output logic       at_speed,
  output logic       busy
);

  localparam logic [7:0] SLOW8      = 8'(SLOW_VAL);
  localparam logic [7:0] STEP8      = 8'(STEP);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMP     = 2'd1,
    HOLD     = 2'd2,
    STOPPING = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [7:0] tgt_q, tgt_n;
  logic [7:0] dwell_cnt, dwell_n;
  logic [7:0] delay_n;
  logic       motor_en_n, at_speed_n, busy_n;

  logic [7:0] tgt_clamp;
  logic [8:0] diff, sum;
  logic [7:0] stepped;

  always_comb begin
    tgt_clamp = (target > SLOW8) ? SLOW8 : target;
  end

  // One STEP toward tgt_q in 9 bits so borrow/carry saturate at the target.
  always_comb begin
    diff = {1'b0, delay_val} - {1'b0, STEP8};
    sum  = {1'b0, delay_val} + {1'b0, STEP8};
    if (delay_val > tgt_q) begin
      stepped = (diff[8] || (diff[7:0] < tgt_q)) ? tgt_q : diff[7:0];
    end else begin
      stepped = (sum > {1'b0, tgt_q}) ? tgt_q : sum[7:0];
    end
  end

  always_comb begin
    state_n    = state;
    tgt_n      = tgt_q;
    dwell_n    = dwell_cnt;
    delay_n    = delay_val;
    motor_en_n = motor_en;
    at_speed_n = at_speed;
    busy_n     = busy;

    case (state)
      IDLE: begin
        dwell_n = 8'd0;
        if (start && !stop) begin
          tgt_n      = tgt_clamp;
          motor_en_n = 1'b1;
          busy_n     = 1'b1;
          if (tgt_clamp == delay_val) begin
            state_n    = HOLD;
            at_speed_n = 1'b1;
          end else begin
            state_n = RAMP;
          end
        end
      end

      RAMP: begin
        if (stop) begin
          state_n    = STOPPING;
          tgt_n      = SLOW8;
          dwell_n    = 8'd0;
          at_speed_n = 1'b0;
        end else if (start) begin
          tgt_n   = tgt_clamp;
          dwell_n = 8'd0;
        end else if (delay_val == tgt_q) begin
          state_n    = HOLD;
          at_speed_n = 1'b1;
          dwell_n    = 8'd0;
        end else if (tick) begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_n = 8'd0;
            delay_n = stepped;
          end else begin
            dwell_n = dwell_cnt + 8'd1;
          end
        end
      end

      HOLD: begin
        dwell_n = 8'd0;
        if (stop) begin
          state_n    = STOPPING;
          tgt_n      = SLOW8;
          at_speed_n = 1'b0;
        end else begin
          // Target is tracked live here; any difference restarts the ramp.
          tgt_n = tgt_clamp;
          if (tgt_clamp != delay_val) begin
            state_n    = RAMP;
            at_speed_n = 1'b0;
          end else begin
            at_speed_n = 1'b1;
          end
        end
      end

      STOPPING: begin
        if (delay_val == SLOW8) begin
          state_n    = IDLE;
          motor_en_n = 1'b0;
          busy_n     = 1'b0;
          dwell_n    = 8'd0;
        end else if (tick) begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_n = 8'd0;
            delay_n = stepped;
          end else begin
            dwell_n = dwell_cnt + 8'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state     <= IDLE;
      tgt_q     <= SLOW8;
      dwell_cnt <= 8'd0;
      delay_val <= SLOW8;
      motor_en  <= 1'b0;
      at_speed  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      tgt_q     <= tgt_n;
      dwell_cnt <= dwell_n;
      delay_val <= delay_n;
      motor_en  <= motor_en_n;
      at_speed  <= at_speed_n;
      busy      <= busy_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rock_speed_ramp.sv
// ============================================================================
// tb_rock_speed_ramp : directed scoreboard bench for rock_speed_ramp.
//                                                            rev 1.0
// ============================================================================
`default_nettype none

module tb_rock_speed_ramp;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [7:0] target = 8'd255;
  logic [7:0] delay_val;
  logic       motor_en, at_speed, busy;

  logic       start2 = 1'b0, stop2 = 1'b0;
  logic [7:0] target2 = 8'd230;
  logic [7:0] delay_val2;
  logic       motor_en2, at_speed2, busy2;

  int         total = 0;
  int         bad = 0;
  int         exp_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] prev = 8'd255;

  rock_speed_ramp #(.STEP(4), .DWELL(2), .SLOW_VAL(255)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .stop(stop), .target(target),
    .tick(tick), .delay_val(delay_val), .motor_en(motor_en),
    .at_speed(at_speed), .busy(busy)
  );

  rock_speed_ramp #(.STEP(4), .DWELL(2), .SLOW_VAL(200)) dut2 (
    .CLK(CLK), .Reset(Reset), .start(start2), .stop(stop2), .target(target2),
    .tick(tick), .delay_val(delay_val2), .motor_en(motor_en2),
    .at_speed(at_speed2), .busy(busy2)
  );

  always #5 CLK = ~CLK;

  // Divider stand-in: one-cycle tick every 5 clocks.
  initial begin
    forever begin
      repeat (4) @(negedge CLK);
      tick = 1'b1;
      @(negedge CLK);
      tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // sel 0: delay_val==v, 1: at_speed==1, 2: busy==0
  task automatic wait_for(input string tag, input int sel, input logic [7:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge CLK);
      case (sel)
        0:       hit = (delay_val === v);
        1:       hit = (at_speed === 1'b1);
        default: hit = (busy === 1'b0);
      endcase
    end
    chk(tag, int'(hit), 1);
  endtask

  task automatic pulse_start(input logic [7:0] t, input logic with_stop);
    @(negedge CLK);
    target = t;
    start  = 1'b1;
    stop   = with_stop;
    @(negedge CLK);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Scoreboard consumer: every change of delay_val must match the next push.
  initial begin
    int e;
    forever begin
      @(negedge CLK);
      if (mon_en && (delay_val !== prev)) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_change", int'(delay_val), int'(prev));
        end else begin
          e = exp_q.pop_front();
          chk("sb_delay", int'(delay_val), e);
        end
        prev = delay_val;
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_delay", int'(delay_val), 255);
    chk("rst_motor_en", int'(motor_en), 0);
    chk("rst_at_speed", int'(at_speed), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_delay2", int'(delay_val2), 200);
    Reset  = 1'b1;
    mon_en = 1'b1;

    // Soft start to 243
    exp_q.push_back(251); exp_q.push_back(247); exp_q.push_back(243);
    pulse_start(8'd243, 1'b0);
    chk("start_motor_en", int'(motor_en), 1);
    chk("start_busy", int'(busy), 1);
    chk("start_at_speed_low", int'(at_speed), 0);
    wait_for("soft_start_at_speed", 1, 8'd0);
    chk("soft_start_delay", int'(delay_val), 243);
    chk("soft_start_drain", exp_q.size(), 0);

    // Retarget in HOLD: 243 -> 250, last step saturates
    exp_q.push_back(247); exp_q.push_back(250);
    target = 8'd250;
    @(negedge CLK);
    chk("retarget_at_speed_drop", int'(at_speed), 0);
    wait_for("retarget_at_speed", 1, 8'd0);
    chk("retarget_delay", int'(delay_val), 250);

    // Move down to 248 (single saturated step), then stop
    exp_q.push_back(248);
    target = 8'd248;
    @(negedge CLK);
    wait_for("to248_at_speed", 1, 8'd0);
    chk("to248_delay", int'(delay_val), 248);
    exp_q.push_back(252); exp_q.push_back(255);
    @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    chk("stop_at_speed_drop", int'(at_speed), 0);
    wait_for("stop_reach_255", 0, 8'd255);
    chk("stop_busy_still", int'(busy), 1);
    @(negedge CLK);
    chk("stop_busy_clear", int'(busy), 0);
    chk("stop_motor_off", int'(motor_en), 0);
    chk("stop_drain", exp_q.size(), 0);

    // Saturation: 255 -> 253 in one step
    exp_q.push_back(253);
    pulse_start(8'd253, 1'b0);
    wait_for("sat_at_speed", 1, 8'd0);
    chk("sat_delay", int'(delay_val), 253);
    exp_q.push_back(255);
    @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    wait_for("sat_stop_idle", 2, 8'd0);

    // Priority: start&stop in RAMP -> STOPPING; start in STOPPING ignored
    exp_q.push_back(251);
    pulse_start(8'd243, 1'b0);
    wait_for("prio_reach_251", 0, 8'd251);
    exp_q.push_back(255);
    pulse_start(8'd200, 1'b1);
    chk("prio_busy", int'(busy), 1);
    chk("prio_at_speed", int'(at_speed), 0);
    pulse_start(8'd200, 1'b0);
    wait_for("prio_idle", 2, 8'd0);
    chk("prio_delay", int'(delay_val), 255);
    chk("prio_motor_off", int'(motor_en), 0);

    // Reset mid-ramp at 247
    exp_q.push_back(251); exp_q.push_back(247);
    pulse_start(8'd200, 1'b0);
    wait_for("rst_mid_reach_247", 0, 8'd247);
    exp_q.push_back(255);
    Reset = 1'b0;
    @(negedge CLK);
    chk("rst_mid_delay", int'(delay_val), 255);
    chk("rst_mid_motor_en", int'(motor_en), 0);
    chk("rst_mid_busy", int'(busy), 0);
    Reset = 1'b1;
    repeat (12) @(negedge CLK);
    chk("rst_mid_stays_parked", int'(delay_val), 255);
    chk("rst_mid_drain", exp_q.size(), 0);

    // Clamp on SLOW_VAL=200 instance: target 230 -> HOLD directly
    @(negedge CLK);
    start2 = 1'b1;
    @(negedge CLK);
    start2 = 1'b0;
    chk("clamp_at_speed", int'(at_speed2), 1);
    chk("clamp_busy", int'(busy2), 1);
    chk("clamp_delay", int'(delay_val2), 200);
    chk("clamp_motor_en", int'(motor_en2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
